divider: RTL and testbench
==========================

# divider

Iterative 32-bit radix-2 divider for the EX stage, the inverse of the existing combinational multiplier. It computes DIV and DIVU results for HI and LO over 32 iteration cycles. It handshakes with the EX stage through `start`/`done` and drives `busy` so the pipeline can stall. It supports pipeline-flush cancellation.

## Interface
Parameters:
- none (data width fixed at 32 bits)

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-low; one clock; clears all state and outputs
- `start`  in  1  request a division; sampled only in IDLE
- `cancel`  in  1  flush or exception kill; aborts any operation
- `is_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; captured with `start`
- `operand_1`  in  32  dividend; captured with `start`
- `operand_2`  in  32  divisor; captured with `start`
- `busy`  out  1  high while an operation is accepted but `done` has not yet fired
- `done`  out  1  one-cycle pulse; `result_div` is valid in this cycle
- `result_div`  out  64  {remainder[63:32] → HI, quotient[31:0] → LO}

## Operation
States: IDLE, DIV_ZERO, DIVIDING, FINISH.

Transitions:
- IDLE, `start`=1, `operand_2`≠0 → DIVIDING.
  - Capture operands as absolute values when `is_signed`; raw values otherwise.
  - Capture sign flags: quotient negate = `is_signed` & (op1[31]^op2[31]); remainder negate = `is_signed` & op1[31].
  - Iteration counter = 0.
- IDLE, `start`=1, `operand_2`=0 → DIV_ZERO.
- DIV_ZERO → FINISH with result {remainder = `operand_1` as captured (unmodified), quotient = 32'hFFFFFFFF}. No sign correction.
- DIVIDING: one restoring step per cycle on a 65-bit working register {partial_rem[32:0], dividend[31:0]}:
  - shift left 1, then trial subtract divisor from the upper 33 bits;
  - if non-negative, keep the difference and set quotient LSB = 1; else restore and set LSB = 0.
  - After counter reaches 31 (32 steps), apply the two's-complement negations per the captured flags → FINISH.
- FINISH: `done`=1 for this cycle, `result_div` registered → IDLE.

Control rules:
- `cancel`=1 in any state → IDLE next cycle; no `done`. `cancel` has priority over `start` in the same cycle.
- `start` while not IDLE is ignored; operands are not re-captured.
- Reset mid-operation behaves like `cancel`, and additionally clears `result_div`.

Output rules:
- `result_div` holds its last value through IDLE until the next FINISH. Cancel does not clear it.
- `busy` = (state ≠ IDLE) & ~`done`.

Arithmetic:
- abs(0x80000000) = 0x80000000 when treated as unsigned 32-bit.
- Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Remainder sign follows the dividend; quotient truncates toward zero.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result_div`=64'h0.
- `start` accepted at edge T0.
  - Normal divide: `busy`=1 during T0+1 … T0+33; `done`=1 at T0+34. Latency is 34 cycles from the start edge to `done`.
  - Divide by zero: `busy`=1 at T0+1; `done`=1 at T0+2.
- `busy` falls in the same cycle that `done` rises.
- A new `start` is accepted in the first IDLE cycle after `done`, i.e. T0+35 at the earliest.
- `cancel` asserted in cycle C: `busy`=0 from C+1; a `start` in C+1 is accepted.

## Test plan
- Unsigned 100 / 7 (`is_signed`=0) → `done` exactly 34 cycles after start; `result_div` = {32'd2, 32'd14}; `busy` high for 33 cycles.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) → {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7 / -2 → {0x00000001, 0xFFFFFFFD}.
- 0x80000000 / 0xFFFFFFFF:
  - signed → {0x00000000, 0x80000000};
  - unsigned → {0x80000000, 0x00000000}.
- Divide by zero: 0x12345678 / 0, either sign mode → `done` at T0+2, result {0x12345678, 0xFFFFFFFF}.
- `cancel` at cycle 10 of DIVIDING → no `done`; `result_div` retains its prior value; a `start` on the next cycle with 9 / 3 → {0, 3} after 34 cycles.
- `start` pulsed again mid-operation with different operands → ignored; the original result is delivered. `rst`=0 mid-operation → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/divider.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Produces {remainder, quotient} after 32 shift/subtract steps plus one sign-fix cycle.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cancel,
  input  logic        is_signed,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  output logic        busy,
  output logic        done,
  output logic [63:0] result_div
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DIV_ZERO = 2'd1;
  localparam logic [1:0] DIVIDING = 2'd2;
  localparam logic [1:0] FINISH   = 2'd3;

  logic [1:0]  state_q,   state_d;
  logic [5:0]  cnt_q,     cnt_d;
  logic [31:0] rem_q,     rem_d;
  logic [31:0] dvd_q,     dvd_d;
  logic [31:0] dsr_q,     dsr_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q,  result_d;

  logic [31:0] op1_abs;
  logic [31:0] op2_abs;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  // Negation wraps, so abs(0x80000000) stays 0x80000000 as an unsigned magnitude.
  assign op1_abs = (is_signed && operand_1[31]) ? (32'd0 - operand_1) : operand_1;
  assign op2_abs = (is_signed && operand_2[31]) ? (32'd0 - operand_2) : operand_2;

  // The partial remainder is always below the divisor, so after the shift it fits
  // in 33 bits and the sign of the 33-bit difference is the restore decision.
  assign shifted = {rem_q, dvd_q[31]};
  assign diff    = shifted - {1'b0, dsr_q};

  assign quo_fix = neg_quo_q ? (32'd0 - dvd_q) : dvd_q;
  assign rem_fix = neg_rem_q ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (operand_2 == 32'd0) begin
            state_d = DIV_ZERO;
            dvd_d   = operand_1;
          end else begin
            state_d   = DIVIDING;
            dvd_d     = op1_abs;
            dsr_d     = op2_abs;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = is_signed & (operand_1[31] ^ operand_2[31]);
            neg_rem_d = is_signed & operand_1[31];
          end
        end
      end
      DIV_ZERO: begin
        result_d = {dvd_q, 32'hFFFF_FFFF};
        state_d  = FINISH;
      end
      DIVIDING: begin
        if (cnt_q == 6'd32) begin
          result_d = {rem_fix, quo_fix};
          state_d  = FINISH;
        end else begin
          rem_d = diff[32] ? shifted[31:0] : diff[31:0];
          dvd_d = {dvd_q[30:0], ~diff[32]};
          cnt_d = cnt_q + 6'd1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cancel) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign done       = (state_q == FINISH);
  assign busy       = (state_q != IDLE) && !done;
  assign result_div = result_q;

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: directed operations push expected results,
// a negedge monitor pops and checks result and arrival cycle on every done.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cancel;
  logic        is_signed;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        busy;
  logic        done;
  logic [63:0] result_div;

  divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cancel     (cancel),
    .is_signed  (is_signed),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .busy       (busy),
    .done       (done),
    .result_div (result_div)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] res;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with result %h expected no done", result_div);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, result_div, e.res);
        chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.due));
      end
    end
  end

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input string name, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input bit push);
    int unsigned lat;
    start     = 1'b1;
    is_signed = sgn;
    operand_1 = a;
    operand_2 = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = (b == 32'd0) ? 1 : 33;
    if (push) sb.push_back('{exp, cyc + lat, name});
  endtask

  task automatic wait_done(input string name, output int unsigned busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
        return;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got no done expected done within 60 cycles", name);
  endtask

  task automatic run(input string name, input logic sgn, input logic [31:0] a,
                     input logic [31:0] b, input logic [63:0] exp, output int unsigned bc);
    issue(name, sgn, a, b, exp, 1'b1);
    wait_done(name, bc);
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bc;
    rst       = 1'b0;
    start     = 1'b0;
    cancel    = 1'b0;
    is_signed = 1'b0;
    operand_1 = '0;
    operand_2 = '0;

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", result_div, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, bc);
    chk("u100_7_busy_cycles", 64'(bc), 64'd33);

    run("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, bc);
    run("s_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, bc);
    run("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, bc);
    run("u_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, bc);

    run("div0_s", 1'b1, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, bc);
    chk("div0_s_busy_cycles", 64'(bc), 64'd1);
    run("div0_u", 1'b0, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, bc);
    chk("div0_u_busy_cycles", 64'(bc), 64'd1);

    // Cancel in the tenth DIVIDING cycle, then restart immediately.
    issue("cancelled", 1'b0, 32'd1000, 32'd3, 64'd0, 1'b0);
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_keeps_result", result_div, {32'h1234_5678, 32'hFFFF_FFFF});
    cancel = 1'b0;
    issue("after_cancel", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b1);
    wait_done("after_cancel", bc);
    @(negedge clk);

    // A second start mid-operation must not disturb the first.
    issue("first_of_two", 1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 1'b1);
    repeat (5) @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b1;
    operand_1 = 32'd77;
    operand_2 = 32'd4;
    @(negedge clk);
    start = 1'b0;
    wait_done("first_of_two", bc);
    @(negedge clk);

    // Reset mid-operation clears everything and yields no done.
    issue("reset_op", 1'b0, 32'd1000, 32'd7, 64'd0, 1'b0);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", result_div, 64'd0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("sb_empty_after_rst", 64'(sb.size()), 64'd0);

    run("u_max_16", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF}, bc);
    repeat (5) @(negedge clk);
    chk("sb_empty_final", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
